// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall and redirect flush bubbles.
// Optional inserted-bubble counter enabled by defining ID_EX_BUBBLE_CNT_EN.
package id_ex_pkg;
  typedef enum logic [1:0] {
    NO_WRITEBACK = 2'd0,
    WB_ALU       = 2'd1,
    WB_MEM       = 2'd2,
    WB_PC4       = 2'd3
  } write_back_mux_selector;

  localparam logic [6:0] OPCODE_LOAD   = 7'h03;
  localparam logic [6:0] OPCODE_OP_IMM = 7'h13;
  localparam logic [6:0] OPCODE_AUIPC  = 7'h17;
  localparam logic [6:0] OPCODE_STORE  = 7'h23;
  localparam logic [6:0] OPCODE_OP     = 7'h33;
  localparam logic [6:0] OPCODE_LUI    = 7'h37;
  localparam logic [6:0] OPCODE_BRANCH = 7'h63;
  localparam logic [6:0] OPCODE_JAL    = 7'h6F;
endpackage

module id_ex_stage
  import id_ex_pkg::*;
#(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned FLUSH_BUBBLES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   id_valid_ip,
  input  logic [6:0]             id_instr_opcode_ip,
  input  logic [4:0]             id_rs1_ip,
  input  logic [4:0]             id_rs2_ip,
  input  logic [4:0]             id_rd_ip,
  input  logic [DATA_W-1:0]      id_rs1_data_ip,
  input  logic [DATA_W-1:0]      id_rs2_data_ip,
  input  logic [DATA_W-1:0]      id_imm_ip,
  input  write_back_mux_selector id_wb_mux_ip,
  input  logic                   ex_redirect_ip,
  output logic                   ex_valid_op,
  output logic [6:0]             ex_instr_opcode_op,
  output logic [4:0]             ex_rs1_op,
  output logic [4:0]             ex_rs2_op,
  output logic [4:0]             ex_rd_op,
  output logic [DATA_W-1:0]      ex_rs1_data_op,
  output logic [DATA_W-1:0]      ex_rs2_data_op,
  output logic [DATA_W-1:0]      ex_imm_op,
  output write_back_mux_selector ex_wb_mux_op,
  output logic                   stall_op,
  output logic [31:0]            bubble_cnt_op
);

  typedef enum logic [1:0] {RUN, LU_STALL, FLUSH} state_e;

  state_e     r_state;
  logic [2:0] r_fcnt;
  logic       w_rs1_used;
  logic       w_rs2_used;
  logic       w_hazard;
  logic       w_load_bubble;

  // Which source registers the decoded instruction actually reads
  assign w_rs1_used = (id_instr_opcode_ip != OPCODE_LUI) &&
                      (id_instr_opcode_ip != OPCODE_AUIPC) &&
                      (id_instr_opcode_ip != OPCODE_JAL);
  assign w_rs2_used = (id_instr_opcode_ip == OPCODE_OP) ||
                      (id_instr_opcode_ip == OPCODE_STORE) ||
                      (id_instr_opcode_ip == OPCODE_BRANCH);

  assign w_hazard = (r_state == RUN) && ex_valid_op &&
                    (ex_instr_opcode_op == OPCODE_LOAD) && (ex_rd_op != 5'd0) &&
                    id_valid_ip &&
                    ((w_rs1_used && (id_rs1_ip == ex_rd_op)) ||
                     (w_rs2_used && (id_rs2_ip == ex_rd_op)));

  // Redirect always wins over a load-use stall
  assign stall_op      = reset && !ex_redirect_ip && w_hazard;
  assign w_load_bubble = ex_redirect_ip || w_hazard || (r_state == FLUSH);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= RUN;
      r_fcnt  <= 3'd0;
    end else if (ex_redirect_ip) begin
      r_fcnt  <= 3'(FLUSH_BUBBLES - 1);
      r_state <= (FLUSH_BUBBLES > 1) ? FLUSH : RUN;
    end else begin
      case (r_state)
        RUN:      if (w_hazard) r_state <= LU_STALL;
        LU_STALL: r_state <= RUN;
        FLUSH: begin
          r_fcnt <= r_fcnt - 3'd1;
          if (r_fcnt <= 3'd1) r_state <= RUN;
        end
        default:  r_state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || w_load_bubble) begin
      ex_valid_op        <= 1'b0;
      ex_instr_opcode_op <= 7'h00;
      ex_rs1_op          <= 5'd0;
      ex_rs2_op          <= 5'd0;
      ex_rd_op           <= 5'd0;
      ex_rs1_data_op     <= '0;
      ex_rs2_data_op     <= '0;
      ex_imm_op          <= '0;
      ex_wb_mux_op       <= NO_WRITEBACK;
    end else begin
      ex_valid_op        <= id_valid_ip;
      ex_instr_opcode_op <= id_instr_opcode_ip;
      ex_rs1_op          <= id_rs1_ip;
      ex_rs2_op          <= id_rs2_ip;
      ex_rd_op           <= id_rd_ip;
      ex_rs1_data_op     <= id_rs1_data_ip;
      ex_rs2_data_op     <= id_rs2_data_ip;
      ex_imm_op          <= id_imm_ip;
      ex_wb_mux_op       <= id_wb_mux_ip;
    end
  end

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [31:0] r_bubble_cnt;

  // Saturating count of hazard/redirect bubbles
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_bubble_cnt <= 32'd0;
    end else if (w_load_bubble && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
      r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign bubble_cnt_op = r_bubble_cnt;
`else
  assign bubble_cnt_op = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage against an instruction-level pipeline model.
module tb_id_ex_stage;
  import id_ex_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned FB = 2;

  typedef struct packed {
    logic          v;
    logic [6:0]    op;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [4:0]    rd;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    logic [DW-1:0] imm;
    logic [1:0]    wb;
  } slot_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic id_valid = 1'b0;
  logic [6:0] id_op = 7'h00;
  logic [4:0] id_rs1 = 5'd0, id_rs2 = 5'd0, id_rd = 5'd0;
  logic [DW-1:0] id_d1 = '0, id_d2 = '0, id_imm = '0;
  write_back_mux_selector id_wb = NO_WRITEBACK;
  logic redirect = 1'b0;

  logic ex_valid;
  logic [6:0] ex_op;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic [DW-1:0] ex_d1, ex_d2, ex_imm;
  write_back_mux_selector ex_wb;
  logic stall;
  logic [31:0] bcnt;

  int total = 0;
  int bad = 0;

  // Reference model: what should sit in EX, bubbles still owed, stall just taken
  slot_t m_slot = '0;
  int m_pend = 0;
  bit m_stalled = 1'b0;
  longint unsigned m_cnt = 0;

  id_ex_stage #(.DATA_W(DW), .FLUSH_BUBBLES(FB)) dut (
    .clk(clk), .reset(reset),
    .id_valid_ip(id_valid), .id_instr_opcode_ip(id_op),
    .id_rs1_ip(id_rs1), .id_rs2_ip(id_rs2), .id_rd_ip(id_rd),
    .id_rs1_data_ip(id_d1), .id_rs2_data_ip(id_d2), .id_imm_ip(id_imm),
    .id_wb_mux_ip(id_wb), .ex_redirect_ip(redirect),
    .ex_valid_op(ex_valid), .ex_instr_opcode_op(ex_op),
    .ex_rs1_op(ex_rs1), .ex_rs2_op(ex_rs2), .ex_rd_op(ex_rd),
    .ex_rs1_data_op(ex_d1), .ex_rs2_data_op(ex_d2), .ex_imm_op(ex_imm),
    .ex_wb_mux_op(ex_wb), .stall_op(stall), .bubble_cnt_op(bcnt)
  );

  always #5 clk = ~clk;

  function automatic slot_t obs();
    return {ex_valid, ex_op, ex_rs1, ex_rs2, ex_rd, ex_d1, ex_d2, ex_imm, 2'(ex_wb)};
  endfunction

  function automatic slot_t id_slot();
    return {id_valid, id_op, id_rs1, id_rs2, id_rd, id_d1, id_d2, id_imm, 2'(id_wb)};
  endfunction

  function automatic logic [31:0] exp_cnt();
`ifdef ID_EX_BUBBLE_CNT_EN
    return 32'(m_cnt);
`else
    return 32'd0;
`endif
  endfunction

  // Does the ID instruction read the register the load in EX is about to write?
  function automatic bit hazard();
    bit reads1, reads2;
    reads1 = !(id_op inside {OPCODE_LUI, OPCODE_AUIPC, OPCODE_JAL});
    reads2 = id_op inside {OPCODE_OP, OPCODE_STORE, OPCODE_BRANCH};
    return m_slot.v && (m_slot.op == OPCODE_LOAD) && (m_slot.rd != 5'd0) && id_valid &&
           ((reads1 && id_rs1 == m_slot.rd) || (reads2 && id_rs2 == m_slot.rd));
  endfunction

  function automatic bit exp_stall();
    return reset && !redirect && (m_pend == 0) && !m_stalled && hazard();
  endfunction

  task automatic set_id(input logic v, input logic [6:0] op, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [4:0] rd, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input write_back_mux_selector wb);
    id_valid = v; id_op = op; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
    id_d1 = a; id_d2 = b; id_imm = $urandom; id_wb = wb;
  endtask

  // Advance one clock edge, updating the model from the inputs presented to it
  task automatic tick();
    slot_t nxt;
    int pend;
    bit st, bub;
    longint unsigned cnt;
    pend = m_pend; st = 1'b0; bub = 1'b0; cnt = m_cnt;
    if (!reset) begin
      nxt = '0; pend = 0; cnt = 0;
    end else begin
      if (redirect) begin bub = 1'b1; pend = int'(FB) - 1; end
      else if (m_pend > 0) begin bub = 1'b1; pend = m_pend - 1; end
      else if (!m_stalled && hazard()) begin bub = 1'b1; st = 1'b1; end
      nxt = bub ? slot_t'('0) : id_slot();
      if (bub && cnt < 64'h0000_0000_FFFF_FFFF) cnt++;
    end
    @(posedge clk);
    m_slot = nxt; m_pend = pend; m_stalled = st; m_cnt = cnt;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; redirect = 1'b1;
    set_id(1'b1, OPCODE_OP, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, WB_ALU);
    #1;
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b exp=0", stall); end
    tick(); tick();
    total++;
    if (obs() !== slot_t'('0)) begin bad++; $display("FAIL reset_slot got=%h exp=0", obs()); end
    total++;
    if (bcnt !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%h exp=0", bcnt); end
    redirect = 1'b0; reset = 1'b1;
  endtask

  task automatic test_plain_pass();
    set_id(1'b1, OPCODE_OP, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, WB_ALU);
    #1;
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL pass_stall got=%0b exp=0", stall); end
    tick();
    total++;
    if ({ex_valid, ex_rd, ex_d1, ex_d2} !== {1'b1, 5'd3, 32'd5, 32'd7})
      begin bad++; $display("FAIL pass_fields got=%0b/%0d/%0d/%0d exp=1/3/5/7", ex_valid, ex_rd, ex_d1, ex_d2); end
    total++;
    if (obs() !== m_slot) begin bad++; $display("FAIL pass_slot got=%h exp=%h", obs(), m_slot); end
  endtask

  task automatic test_load_use();
    logic [31:0] c0;
    set_id(1'b1, OPCODE_LOAD, 5'd1, 5'd0, 5'd5, 32'd0, 32'd0, WB_MEM);
    tick();
    c0 = bcnt;
    set_id(1'b1, OPCODE_OP, 5'd5, 5'd1, 5'd6, 32'd11, 32'd22, WB_ALU);
    #1;
    total++;
    if (stall !== 1'b1) begin bad++; $display("FAIL lu_stall got=%0b exp=1", stall); end
    tick();
    total++;
    if (ex_valid !== 1'b0 || stall !== 1'b0)
      begin bad++; $display("FAIL lu_bubble got=v%0b/s%0b exp=v0/s0", ex_valid, stall); end
    tick();
    total++;
    if ({ex_valid, ex_op, ex_rd} !== {1'b1, OPCODE_OP, 5'd6})
      begin bad++; $display("FAIL lu_issue got=%0b/%h/%0d exp=1/33/6", ex_valid, ex_op, ex_rd); end
    total++;
    if (bcnt - c0 !== exp_cnt() - c0)
      begin bad++; $display("FAIL lu_cnt got=%h exp=%h", bcnt, exp_cnt()); end
  endtask

  task automatic test_no_false_hazard();
    set_id(1'b1, OPCODE_LOAD, 5'd1, 5'd0, 5'd0, 32'd0, 32'd0, WB_MEM);
    tick();
    set_id(1'b1, OPCODE_OP, 5'd0, 5'd0, 5'd6, 32'd1, 32'd1, WB_ALU);
    #1;
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL x0_stall got=%0b exp=0", stall); end
    set_id(1'b1, OPCODE_LOAD, 5'd1, 5'd0, 5'd5, 32'd0, 32'd0, WB_MEM);
    tick();
    set_id(1'b1, OPCODE_LUI, 5'd5, 5'd5, 5'd5, 32'd3, 32'd4, WB_ALU);
    #1;
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL lui_stall got=%0b exp=0", stall); end
    tick();
    total++;
    if ({ex_valid, ex_op} !== {1'b1, OPCODE_LUI})
      begin bad++; $display("FAIL lui_issue got=%0b/%h exp=1/37", ex_valid, ex_op); end
  endtask

  task automatic test_redirect();
    set_id(1'b1, OPCODE_OP, 5'd2, 5'd3, 5'd4, 32'd9, 32'd8, WB_ALU);
    redirect = 1'b1;
    tick();
    redirect = 1'b0;
    total++;
    if (ex_valid !== 1'b0) begin bad++; $display("FAIL rd_bub1 got=%0b exp=0", ex_valid); end
    tick();
    total++;
    if (ex_valid !== 1'b0) begin bad++; $display("FAIL rd_bub2 got=%0b exp=0", ex_valid); end
    tick();
    total++;
    if ({ex_valid, ex_rd} !== {1'b1, 5'd4})
      begin bad++; $display("FAIL rd_capture got=%0b/%0d exp=1/4", ex_valid, ex_rd); end
    set_id(1'b1, OPCODE_LOAD, 5'd1, 5'd0, 5'd7, 32'd0, 32'd0, WB_MEM);
    tick();
    set_id(1'b1, OPCODE_STORE, 5'd1, 5'd7, 5'd0, 32'd0, 32'd0, NO_WRITEBACK);
    redirect = 1'b1;
    #1;
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL rd_vs_hz got=%0b exp=0", stall); end
    tick();
    redirect = 1'b0;
    total++;
    if (obs() !== m_slot) begin bad++; $display("FAIL rd_vs_hz_slot got=%h exp=%h", obs(), m_slot); end
    tick(); tick();
  endtask

  task automatic test_reset_mid_flush();
    redirect = 1'b1;
    tick();
    redirect = 1'b0; reset = 1'b0;
    tick();
    total++;
    if (ex_valid !== 1'b0 || bcnt !== 32'd0)
      begin bad++; $display("FAIL rmf_slot got=v%0b/c%h exp=v0/c0", ex_valid, bcnt); end
    reset = 1'b1;
    set_id(1'b1, OPCODE_OP, 5'd1, 5'd2, 5'd9, 32'd1, 32'd2, WB_ALU);
    tick();
    total++;
    if ({ex_valid, ex_rd} !== {1'b1, 5'd9})
      begin bad++; $display("FAIL rmf_run got=%0b/%0d exp=1/9", ex_valid, ex_rd); end
  endtask

  task automatic test_counter_saturate();
`ifdef ID_EX_BUBBLE_CNT_EN
    dut.r_bubble_cnt = 32'hFFFF_FFFD;
    m_cnt = 64'h0000_0000_FFFF_FFFD;
`endif
    set_id(1'b1, OPCODE_OP, 5'd1, 5'd2, 5'd3, 32'd0, 32'd0, WB_ALU);
    redirect = 1'b1;
    tick();
    redirect = 1'b0;
    tick();
    redirect = 1'b1;
    tick();
    redirect = 1'b0;
    tick(); tick();
    total++;
    if (bcnt !== exp_cnt()) begin bad++; $display("FAIL cnt_sat got=%h exp=%h", bcnt, exp_cnt()); end
    reset = 1'b0; tick(); reset = 1'b1;
  endtask

  task automatic test_random();
    logic [6:0] ops [8];
    ops = '{OPCODE_LOAD, OPCODE_OP, OPCODE_STORE, OPCODE_BRANCH,
            OPCODE_LUI, OPCODE_AUIPC, OPCODE_JAL, OPCODE_OP_IMM};
    for (int i = 0; i < 400; i++) begin
      set_id(1'($urandom_range(0, 7) != 0), ops[$urandom_range(0, 7)],
             5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)),
             $urandom, $urandom, write_back_mux_selector'($urandom_range(0, 3)));
      redirect = ($urandom_range(0, 9) == 0);
      #1;
      total++;
      if (stall !== exp_stall())
        begin bad++; $display("FAIL rnd_stall i=%0d got=%0b exp=%0b", i, stall, exp_stall()); end
      tick();
      total++;
      if (obs() !== m_slot)
        begin bad++; $display("FAIL rnd_slot i=%0d got=%h exp=%h", i, obs(), m_slot); end
      total++;
      if (bcnt !== exp_cnt())
        begin bad++; $display("FAIL rnd_cnt i=%0d got=%h exp=%h", i, bcnt, exp_cnt()); end
    end
    redirect = 1'b0;
  endtask

  initial begin
    test_reset();
    test_plain_pass();
    test_load_use();
    test_no_false_hazard();
    test_redirect();
    test_reset_mid_flush();
    test_counter_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DATA_W, 32, operand/immediate width.
REQ-002 Parameter FLUSH_BUBBLES, 2, bubbles inserted after a redirect (legal 1..7).
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 id_valid_ip  in  1  decode stage holds a valid instruction.
REQ-006 id_instr_opcode_ip  in  7  decoded opcode.
REQ-007 id_rs1_ip / id_rs2_ip / id_rd_ip  in  5 each  source and destination register indices.
REQ-008 id_rs1_data_ip / id_rs2_data_ip / id_imm_ip  in  DATA_W each  register-file reads and immediate.
REQ-009 id_wb_mux_ip  in  write_back_mux_selector  writeback source of the decoded instruction.
REQ-010 ex_redirect_ip  in  1  taken branch/jump resolved in EX; kills wrong-path work.
REQ-011 ex_valid_op  out  1  ID/EX slot holds a real instruction.
REQ-012 ex_instr_opcode_op  out  7  registered opcode; drives the forwarding controller opcode input.
REQ-013 ex_rs1_op / ex_rs2_op / ex_rd_op  out  5 each  registered indices; rs1/rs2 drive the forwarding controller.
REQ-014 ex_rs1_data_op / ex_rs2_data_op / ex_imm_op  out  DATA_W each  registered operands.
REQ-015 ex_wb_mux_op  out  write_back_mux_selector  registered writeback select.
REQ-016 stall_op  out  1  combinational hold request to PC and IF/ID register.
REQ-017 bubble_cnt_op  out  32  inserted-bubble count (see Configuration).

Function
REQ-018 Bubble = ex_valid_op 0, opcode 7'h00, rs1/rs2/rd 0, data/imm 0, ex_wb_mux_op NO_WRITEBACK.
REQ-019 FSM states RUN, LU_STALL, FLUSH; 3-bit flush counter fcnt.
REQ-020 rs1 used: opcode not LUI, AUIPC, JAL; rs2 used: OPCODE_OP, STORE, BRANCH.
REQ-021 Load-use hazard = ex_valid_op & ex_instr_opcode_op==OPCODE_LOAD & ex_rd_op!=0 & id_valid_ip & ((rs1 used & id_rs1_ip==ex_rd_op) | (rs2 used & id_rs2_ip==ex_rd_op)).
REQ-022 RUN, no redirect, no hazard: next edge captures all ID inputs (ex_valid_op = id_valid_ip); stall_op 0; latency one cycle.
REQ-023 RUN, hazard, no redirect: stall_op 1 same cycle; next edge loads bubble, go LU_STALL.
REQ-024 LU_STALL: stall_op 0, hazard check suppressed; next edge captures ID inputs, go RUN (exactly one bubble per load-use).
REQ-025 Redirect in any state: stall_op 0; next edge loads bubble, fcnt=FLUSH_BUBBLES-1, go FLUSH (FLUSH_BUBBLES=1: go RUN).
REQ-026 FLUSH: stall_op 0; each edge loads bubble, fcnt decrements; at fcnt==0 after load go RUN; redirect in FLUSH restarts fcnt.
REQ-027 Redirect and hazard same cycle: redirect wins, no stall.
REQ-028 rd==x0 never causes a hazard; id_valid_ip 0 never causes a hazard.

Reset
REQ-029 reset low at an edge: state RUN, fcnt 0, ID/EX slot = bubble, bubble_cnt_op 0; overrides stall/redirect.
REQ-030 During reset stall_op 0; first post-reset edge follows REQ-022..026.

Configuration
REQ-031 Macro ID_EX_BUBBLE_CNT_EN defined: bubble_cnt_op increments by 1 on every edge loading a bubble due to hazard or redirect, saturating at 32'hFFFF_FFFF.
REQ-032 Macro undefined: no counter register; bubble_cnt_op tied to 0; all other behaviour identical.

Verification
REQ-033 Plain pass: ADD x3,x1,x2 with rs1 data 5, rs2 data 7 -> next cycle ex_valid_op 1, ex_rd_op 3, data 5/7, stall_op 0.
REQ-034 Load-use: ex holds LW x5; ID ADD x6,x5,x1 -> stall_op 1 one cycle, one bubble, ADD issued following cycle, bubble_cnt_op +1.
REQ-035 No false hazard: ex LW x0, or ID LUI x5 with id_rs1_ip 5 -> stall_op 0, no bubble.
REQ-036 Redirect with FLUSH_BUBBLES=2 -> two consecutive bubbles, third edge captures ID; redirect coincident with hazard -> stall_op 0.
REQ-037 Reset low mid-FLUSH -> next cycle RUN, bubble slot, bubble_cnt_op 0.
REQ-038 Counter build: preload near max, 3 bubbles -> holds 32'hFFFF_FFFF; macro undefined -> stays 0.
